// File: rtl/regfile_gen.sv
`default_nettype none
// ============================================================================
// Module      : regfile_gen
// Description : Parametrised 2-read/1-write register file. After reset a
//               clear sequencer zeroes every entry, one per cycle, then
//               raises ready. Optional hardwired-zero entry 0 and optional
//               same-cycle write-to-read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_gen #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    input  logic [AW-1:0]   A3,
    input  logic [XLEN-1:0] WD3,
    input  logic            WE3,
    output logic            ready
);

    localparam logic [AW-1:0] c_LAST = AW'(NREGS - 1);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t            r_state;
    logic [AW-1:0]     r_ptr;
    logic              r_ready;
    logic [XLEN-1:0]   r_mem [NREGS];

    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_rd1;
    logic [XLEN-1:0]   w_rd2;

    // Clear sequencer: walks ptr over every entry once, then parks in RUN
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    if (r_ptr == c_LAST) begin
                        r_state <= S_RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + AW'(1);
                    end
                end
                S_RUN: begin
                    // ptr is frozen here; nothing to advance
                    r_state <= S_RUN;
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_ptr   <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Array write port: clear writes during CLEAR, user writes only in RUN
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_ptr;
        w_wdata = '0;
        if (rst) begin
            if (r_state == S_CLEAR) begin
                w_we    = 1'b1;
                w_waddr = r_ptr;
                w_wdata = '0;
            end else if (WE3 && !((ZERO_REG != 0) && (A3 == '0))) begin
                w_we    = 1'b1;
                w_waddr = A3;
                w_wdata = WD3;
            end
        end
    end

    // Storage array; contents defined only by the clear pass and writes
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Read port 1: not-ready gate, zero entry, bypass, then stored value
    always_comb begin
        w_rd1 = r_mem[A1];
        if (!r_ready) begin
            w_rd1 = '0;
        end else if ((ZERO_REG != 0) && (A1 == '0)) begin
            w_rd1 = '0;
        end else if ((BYPASS != 0) && WE3 && (A3 == A1)) begin
            w_rd1 = WD3;
        end
    end

    // Read port 2: same priority as port 1, fully independent
    always_comb begin
        w_rd2 = r_mem[A2];
        if (!r_ready) begin
            w_rd2 = '0;
        end else if ((ZERO_REG != 0) && (A2 == '0)) begin
            w_rd2 = '0;
        end else if ((BYPASS != 0) && WE3 && (A3 == A2)) begin
            w_rd2 = WD3;
        end
    end

    assign RD1   = w_rd1;
    assign RD2   = w_rd2;
    assign ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_regfile_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_gen
// Description : Scoreboard bench for regfile_gen. Three instances:
//               a = defaults (bypass, zero reg), b = no bypass / no zero reg
//               (shares a's inputs), c = XLEN 64 / NREGS 16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_gen;

    logic clk;
    logic rst;

    // shared inputs for instances a and b
    logic [4:0]  ab_A1, ab_A2, ab_A3;
    logic [31:0] ab_WD3;
    logic        ab_WE3;
    logic [31:0] a_RD1, a_RD2, b_RD1, b_RD2;
    logic        a_ready, b_ready;

    // inputs for instance c
    logic [3:0]  c_A1, c_A2, c_A3;
    logic [63:0] c_WD3;
    logic        c_WE3;
    logic [63:0] c_RD1, c_RD2;
    logic        c_ready;

    regfile_gen #(.XLEN(32), .NREGS(32), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .A1(ab_A1), .A2(ab_A2), .RD1(a_RD1), .RD2(a_RD2),
        .A3(ab_A3), .WD3(ab_WD3), .WE3(ab_WE3), .ready(a_ready));

    regfile_gen #(.XLEN(32), .NREGS(32), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .A1(ab_A1), .A2(ab_A2), .RD1(b_RD1), .RD2(b_RD2),
        .A3(ab_A3), .WD3(ab_WD3), .WE3(ab_WE3), .ready(b_ready));

    regfile_gen #(.XLEN(64), .NREGS(16), .ZERO_REG(1), .BYPASS(1)) dut_c (
        .clk(clk), .rst(rst), .A1(c_A1), .A2(c_A2), .RD1(c_RD1), .RD2(c_RD2),
        .A3(c_A3), .WD3(c_WD3), .WE3(c_WE3), .ready(c_ready));

    // output selectors for scoreboard entries
    localparam int c_A_RDY = 0, c_A_RD1 = 1, c_A_RD2 = 2;
    localparam int c_B_RDY = 3, c_B_RD1 = 4, c_B_RD2 = 5;
    localparam int c_C_RDY = 6, c_C_RD1 = 7, c_C_RD2 = 8;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] sample(input int sel);
        case (sel)
            c_A_RDY: return {63'd0, a_ready};
            c_A_RD1: return {32'd0, a_RD1};
            c_A_RD2: return {32'd0, a_RD2};
            c_B_RDY: return {63'd0, b_ready};
            c_B_RD1: return {32'd0, b_RD1};
            c_B_RD2: return {32'd0, b_RD2};
            c_C_RDY: return {63'd0, c_ready};
            c_C_RD1: return c_RD1;
            c_C_RD2: return c_RD2;
            default: return 64'hxxxx_xxxx_xxxx_xxxx;
        endcase
    endfunction

    task automatic expect_val(input string name, input int sel, input logic [63:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        q.push_back(e);
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // monitor: on each falling edge, compare every queued expectation
    initial begin
        exp_t        e;
        logic [63:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e   = q.pop_front();
                act = sample(e.sel);
                n_checks++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h (t=%0t)", e.name, act, e.exp, $time);
                end
            end
        end
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        n_fail++;
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b0;
        ab_A1  = 5'd3;  ab_A2 = 5'd3;  ab_A3 = 5'd3;
        ab_WD3 = 32'hAA; ab_WE3 = 1'b1;
        c_A1   = 4'd3;  c_A2 = 4'd3;  c_A3 = 4'd3;
        c_WD3  = 64'hAA; c_WE3 = 1'b1;

        // ---------------- reset held for 3 cycles ----------------
        for (int i = 0; i < 3; i++) begin
            step();
            expect_val("reset_a_ready", c_A_RDY, 64'd0);
            expect_val("reset_a_rd1",   c_A_RD1, 64'd0);
            expect_val("reset_b_ready", c_B_RDY, 64'd0);
            expect_val("reset_c_ready", c_C_RDY, 64'd0);
            expect_val("reset_c_rd1",   c_C_RD1, 64'd0);
        end

        // ---------------- clear sequence, writes held on ----------------
        rst = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            step();
            if (e >= 15) c_WE3 = 1'b0;
            if (e == 32) ab_WE3 = 1'b0;
            expect_val("clear_a_ready", c_A_RDY, (e == 32) ? 64'd1 : 64'd0);
            expect_val("clear_b_ready", c_B_RDY, (e == 32) ? 64'd1 : 64'd0);
            expect_val("clear_c_ready", c_C_RDY, (e >= 16) ? 64'd1 : 64'd0);
            expect_val("clear_a_rd1",   c_A_RD1, 64'd0);
        end

        // all entries read zero on both ports
        for (int i = 0; i < 32; i++) begin
            ab_A1 = 5'(i);
            ab_A2 = 5'(31 - i);
            c_A1  = 4'(i);
            c_A2  = 4'(15 - i);
            expect_val("clr_a_rd1", c_A_RD1, 64'd0);
            expect_val("clr_a_rd2", c_A_RD2, 64'd0);
            expect_val("clr_b_rd1", c_B_RD1, 64'd0);
            expect_val("clr_b_rd2", c_B_RD2, 64'd0);
            if (i < 16) begin
                expect_val("clr_c_rd1", c_C_RD1, 64'd0);
                expect_val("clr_c_rd2", c_C_RD2, 64'd0);
            end
            step();
        end

        // ---------------- basic write / read ----------------
        ab_WE3 = 1'b1; ab_A3 = 5'd5; ab_WD3 = 32'hDEADBEEF;
        c_WE3  = 1'b1; c_A3  = 4'd5; c_WD3  = 64'h0123_4567_89AB_CDEF;
        step();
        ab_A3 = 5'd9; ab_WD3 = 32'h20;
        c_WE3 = 1'b0;
        step();
        ab_WE3 = 1'b0;
        ab_A1 = 5'd5; ab_A2 = 5'd9;
        c_A1  = 4'd5; c_A2  = 4'd9;
        expect_val("wr_a_rd1", c_A_RD1, 64'hDEADBEEF);
        expect_val("wr_a_rd2", c_A_RD2, 64'h20);
        expect_val("wr_b_rd1", c_B_RD1, 64'hDEADBEEF);
        expect_val("wr_b_rd2", c_B_RD2, 64'h20);
        expect_val("wr_c_rd1", c_C_RD1, 64'h0123_4567_89AB_CDEF);
        expect_val("wr_c_rd2", c_C_RD2, 64'd0);
        step();

        // ---------------- bypass ----------------
        ab_WE3 = 1'b1; ab_A3 = 5'd7; ab_WD3 = 32'h1234;
        ab_A1 = 5'd7; ab_A2 = 5'd7;
        expect_val("byp_a_rd1",   c_A_RD1, 64'h1234);
        expect_val("byp_a_rd2",   c_A_RD2, 64'h1234);
        expect_val("nobyp_b_rd1", c_B_RD1, 64'd0);
        expect_val("nobyp_b_rd2", c_B_RD2, 64'd0);
        step();
        ab_WE3 = 1'b0;
        expect_val("post_byp_a_rd1", c_A_RD1, 64'h1234);
        expect_val("post_byp_b_rd2", c_B_RD2, 64'h1234);
        step();

        // ---------------- zero register ----------------
        ab_WE3 = 1'b1; ab_A3 = 5'd0; ab_WD3 = 32'hFFFFFFFF;
        ab_A1 = 5'd0; ab_A2 = 5'd0;
        expect_val("zr_a_rd1_same", c_A_RD1, 64'd0);
        expect_val("zr_b_rd1_same", c_B_RD1, 64'd0);
        step();
        ab_WE3 = 1'b0;
        expect_val("zr_a_rd1_after", c_A_RD1, 64'd0);
        expect_val("zr_b_rd1_after", c_B_RD1, 64'hFFFFFFFF);
        expect_val("zr_b_rd2_after", c_B_RD2, 64'hFFFFFFFF);
        step();

        // writes issued during clear never landed
        ab_A1 = 5'd3;
        c_A1  = 4'd3;
        expect_val("clrwr_a_rd1", c_A_RD1, 64'd0);
        expect_val("clrwr_b_rd1", c_B_RD1, 64'd0);
        expect_val("clrwr_c_rd1", c_C_RD1, 64'd0);
        step();

        // ---------------- reset mid-run ----------------
        ab_WE3 = 1'b1; ab_A3 = 5'd12; ab_WD3 = 32'h55;
        c_WE3  = 1'b1; c_A3  = 4'd12; c_WD3  = 64'h55;
        step();
        ab_WE3 = 1'b0; c_WE3 = 1'b0;
        ab_A1 = 5'd12; c_A1 = 4'd12;
        expect_val("pre_rst_a_rd1", c_A_RD1, 64'h55);
        expect_val("pre_rst_b_rd1", c_B_RD1, 64'h55);
        expect_val("pre_rst_c_rd1", c_C_RD1, 64'h55);
        step();

        rst = 1'b0;
        ab_WE3 = 1'b1; ab_WD3 = 32'h99;
        c_WE3  = 1'b1; c_WD3  = 64'h99;
        step();
        rst = 1'b1;
        ab_WE3 = 1'b0; c_WE3 = 1'b0;
        expect_val("mid_rst_a_ready", c_A_RDY, 64'd0);
        expect_val("mid_rst_b_ready", c_B_RDY, 64'd0);
        expect_val("mid_rst_c_ready", c_C_RDY, 64'd0);
        expect_val("mid_rst_a_rd1",   c_A_RD1, 64'd0);
        for (int e = 1; e <= 32; e++) begin
            step();
            expect_val("reclr_a_ready", c_A_RDY, (e == 32) ? 64'd1 : 64'd0);
            expect_val("reclr_b_ready", c_B_RDY, (e == 32) ? 64'd1 : 64'd0);
            expect_val("reclr_c_ready", c_C_RDY, (e >= 16) ? 64'd1 : 64'd0);
        end
        expect_val("reclr_a_rd1_12", c_A_RD1, 64'd0);
        expect_val("reclr_b_rd1_12", c_B_RD1, 64'd0);
        expect_val("reclr_c_rd1_12", c_C_RD1, 64'd0);
        ab_A2 = 5'd5; c_A2 = 4'd5;
        expect_val("reclr_a_rd2_5", c_A_RD2, 64'd0);
        expect_val("reclr_c_rd2_5", c_C_RD2, 64'd0);
        step();

        // drain scoreboard
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_gen.md
# regfile_gen

Parametrised 2-read/1-write register file for the single-cycle core, replacing the fixed 32x32 block. Width and depth are parameters. Register x0 can be hardwired to zero, and same-cycle write-to-read bypass is optional. After reset, a clear sequencer zeroes every entry one per cycle and then raises `ready`, so the array never exposes uninitialised contents. It sits between decode (addresses) and the ALU/writeback path (data).

## Interface
- `XLEN`, 32, data width in bits.
- `NREGS`, 32, number of registers; power of two, at least 2; `AW = $clog2(NREGS)`.
- `ZERO_REG`, 1, when 1 entry 0 reads as zero and writes to it are discarded.
- `BYPASS`, 1, when 1 a same-cycle write to a read address is forwarded to that read port.

- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `A1`  in  AW  read port 1 address.
- `A2`  in  AW  read port 2 address.
- `RD1`  out  XLEN  read port 1 data, combinational.
- `RD2`  out  XLEN  read port 2 data, combinational.
- `A3`  in  AW  write address.
- `WD3`  in  XLEN  write data.
- `WE3`  in  1  write enable.
- `ready`  out  1  high once the clear sequence is complete and the array is usable.

## Operation
- Two states, CLEAR and RUN, plus a clear pointer `ptr` (AW bits).
- While `rst`=0 at a clock edge: state goes to CLEAR, `ptr` goes to 0, `ready` goes to 0. No array write occurs during reset cycles.
- CLEAR with `rst`=1:
  - Each edge writes 0 to entry `ptr`, then increments `ptr`.
  - When `ptr`=NREGS-1, that entry is written and the state moves to RUN.
  - `WE3` is ignored for the whole of CLEAR.
- RUN: on an edge with `WE3`=1, entry `A3` receives `WD3`. The exception is `A3`=0 with `ZERO_REG`=1, where the write is dropped.
- Read port X (X = 1 or 2), in priority order:
  1. `ready`=0 gives 0.
  2. Otherwise, `ZERO_REG`=1 and `AX`=0 gives 0.
  3. Otherwise, `BYPASS`=1, `WE3`=1 and `A3`=`AX` gives `WD3`.
  4. Otherwise, the stored entry at `AX`.
- Both read ports are fully independent; the same address on both is legal.
- There is no initial-value preload. All contents are defined only by the clear sequence and by writes.

## Timing
- Output reset values: `ready`=0 and `RD1`/`RD2`=0 while `ready`=0.
- Clear latency:
  - Reset is released (`rst` sampled 1) at edge E0; this is the first clear write.
  - The final clear write happens at edge E0+NREGS-1, and `ready` is 1 immediately after that edge.
  - For NREGS=32, clearing takes 32 edges.
- Write to read latency:
  - Without bypass, a write at edge N is visible combinationally right after edge N.
  - With bypass, it is also visible in the cycle before edge N, in the same cycle `WE3` is asserted.
- Reset mid-operation (`rst`=0 in RUN or CLEAR):
  - At that edge, `ready` drops to 0 and state goes to CLEAR with `ptr`=0.
  - Any concurrent `WE3` is discarded.
  - The full clear sequence restarts when reset is released.
- Reset for one cycle in the middle of CLEAR restarts `ptr` at 0; no partial-clear shortcut is taken.
- `ptr` never wraps in RUN: it is held constant once clearing ends.
- With `WE3`=1 and `ready`=0 on the same edge, the write is dropped and is not queued.

## Test plan
- Clear sequence (NREGS=32):
  - Stimulus: hold `rst`=0 for 3 cycles, then release.
  - Required: `ready` stays 0 for exactly 32 edges, then goes to 1.
  - Required: after `ready`, all 32 addresses read 0 on both ports.
- Basic write/read:
  - Stimulus: in RUN, write `A3`=5 `WD3`=0xDEADBEEF, then `A3`=9 `WD3`=0x20.
  - Required: next cycle `A1`=5 gives `RD1`=0xDEADBEEF and `A2`=9 gives `RD2`=0x20.
- Bypass:
  - Stimulus: `BYPASS`=1; `WE3`=1, `A3`=7, `WD3`=0x1234, with `A1`=`A2`=7 in the same cycle.
  - Required: `RD1`=`RD2`=0x1234 before the edge.
  - With `BYPASS`=0 the same stimulus must return the old value (0).
- Zero register:
  - Stimulus: `ZERO_REG`=1, write `A3`=0 `WD3`=0xFFFFFFFF.
  - Required: `RD1` at `A1`=0 is 0, both in the write cycle and afterwards.
  - With `ZERO_REG`=0, the read returns 0xFFFFFFFF after the edge.
- Writes during clear are ignored:
  - Stimulus: assert `WE3`=1, `A3`=3, `WD3`=0xAA on every cycle of CLEAR.
  - Required: after `ready`, `A1`=3 reads 0.
- Reset mid-run:
  - Stimulus: write 0x55 to entry 12, then pulse `rst`=0 for 1 cycle with `WE3`=1 on entry 12.
  - Required: `ready`=0 on the next cycle, 32-edge re-clear, and entry 12 reads 0 afterwards.
  - Repeat with the parameter set XLEN=64, NREGS=16; the re-clear takes 16 edges.
